// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared widths, end-of-program sentinel and fetch state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

    localparam int unsigned IP_WIDTH   = 4;
    localparam int unsigned LINE_WIDTH = 32;
    localparam int unsigned NUM_LINES  = 4;

    localparam logic [LINE_WIDTH-1:0] HALT_WORD = 32'hffff_ffff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch sequencer with a one-entry valid/ready slot
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_en,
    output logic [IP_WIDTH-1:0]   ip,
    input  logic [LINE_WIDTH-1:0] line,
    output logic [LINE_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [IP_WIDTH-1:0]   instr_ip,
    input  logic                  redir_valid,
    input  logic [IP_WIDTH-1:0]   redir_ip,
    output logic                  halted,
    output logic [15:0]           fetch_count
);

    fetch_state_t            state_q,       state_d;
    logic [IP_WIDTH-1:0]     pc_q,          pc_d;
    logic [LINE_WIDTH-1:0]   instr_q,       instr_d;
    logic [IP_WIDTH-1:0]     instr_ip_q,    instr_ip_d;
    logic                    instr_valid_q, instr_valid_d;
    logic                    halted_q,      halted_d;
    logic [15:0]             fetch_count_q, fetch_count_d;

    logic w_slot_free;
    logic w_handshake;
    logic w_is_halt;

    assign w_slot_free = !instr_valid_q || instr_ready;
    assign w_handshake = instr_valid_q && instr_ready;
    assign w_is_halt   = (line == HALT_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_ip_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_ip_q    <= instr_ip_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic; a redirect outranks start and sentinel detection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (!redir_valid && w_slot_free && w_is_halt) state_d = HALT;
            end
            HALT: begin
                if (redir_valid || start) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates for pc and the output slot
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_ip_d    = instr_ip_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        if (w_handshake && (fetch_count_q != 16'hffff)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) pc_d = '0;
            end
            FETCH: begin
                if (redir_valid) begin
                    pc_d          = redir_ip;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b0;
                end else if (w_slot_free) begin
                    if (w_is_halt) begin
                        halted_d      = 1'b1;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_d       = line;
                        instr_ip_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 1'b1;
                    end
                end
            end
            HALT: begin
                if (w_handshake) instr_valid_d = 1'b0;
                if (redir_valid) begin
                    pc_d          = redir_ip;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b0;
                end else if (start) begin
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        mem_en = (state_q == FETCH) && w_slot_free;
    end

    assign ip          = pc_q;
    assign instr       = instr_q;
    assign instr_ip    = instr_ip_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed vector bench for fetch_ctrl with a behavioural line store
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  mem_en;
    logic [IP_WIDTH-1:0]   ip;
    logic [LINE_WIDTH-1:0] line;
    logic [LINE_WIDTH-1:0] instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [IP_WIDTH-1:0]   instr_ip;
    logic                  redir_valid;
    logic [IP_WIDTH-1:0]   redir_ip;
    logic                  halted;
    logic [15:0]           fetch_count;

    logic [LINE_WIDTH-1:0] mem [16];
    assign line = mem[ip];

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_en      (mem_en),
        .ip          (ip),
        .line        (line),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_ip    (instr_ip),
        .redir_valid (redir_valid),
        .redir_ip    (redir_ip),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rdy;
        logic        rv;
        logic [3:0]  rip;
        logic        rs;
        logic        v;
        logic [3:0]  iip;
        logic [3:0]  ipx;
        logic        men;
        logic        h;
        logic [15:0] cnt;
    } vec_t;

    vec_t vec [36];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0100 + i;
        mem[0] = 32'hA000_0000;
        mem[1] = 32'hA000_0001;
        mem[2] = 32'hA000_0002;
        mem[3] = 32'hA000_0003;
        mem[NUM_LINES] = HALT_WORD;

        //          st rdy rv rip rs   v iip ip men h cnt
        vec[0]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vec[1]  = '{0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        vec[2]  = '{0, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0};
        vec[3]  = '{0, 1, 0, 0, 0,  1, 1, 2, 1, 0, 1};
        vec[4]  = '{0, 0, 0, 0, 0,  1, 2, 3, 0, 0, 2};
        vec[5]  = '{0, 0, 0, 0, 0,  1, 2, 3, 0, 0, 2};
        vec[6]  = '{0, 0, 0, 0, 0,  1, 2, 3, 0, 0, 2};
        vec[7]  = '{0, 1, 0, 0, 0,  1, 2, 3, 1, 0, 2};
        vec[8]  = '{0, 1, 0, 0, 0,  1, 3, 4, 1, 0, 3};
        vec[9]  = '{0, 1, 0, 0, 0,  0, 3, 4, 0, 1, 4};
        vec[10] = '{0, 1, 0, 0, 0,  0, 3, 4, 0, 1, 4};
        vec[11] = '{1, 1, 0, 0, 0,  0, 3, 4, 0, 1, 4};
        vec[12] = '{0, 0, 0, 0, 0,  0, 3, 0, 1, 0, 4};
        vec[13] = '{0, 1, 0, 0, 0,  1, 0, 1, 1, 0, 4};
        vec[14] = '{0, 0, 0, 0, 0,  1, 1, 2, 0, 0, 5};
        vec[15] = '{0, 1, 0, 0, 0,  1, 1, 2, 1, 0, 5};
        vec[16] = '{0, 1, 0, 0, 0,  1, 2, 3, 1, 0, 6};
        vec[17] = '{0, 0, 0, 0, 0,  1, 3, 4, 0, 0, 7};
        vec[18] = '{0, 0, 1, 1, 0,  1, 3, 4, 0, 0, 7};
        vec[19] = '{0, 0, 0, 0, 0,  0, 3, 1, 1, 0, 7};
        vec[20] = '{0, 1, 0, 0, 0,  1, 1, 2, 1, 0, 7};
        vec[21] = '{0, 1, 0, 0, 1,  1, 2, 3, 1, 0, 8};
        vec[22] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vec[23] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vec[24] = '{1, 1, 1, 9, 0,  0, 0, 0, 0, 0, 0};
        vec[25] = '{0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        vec[26] = '{0, 1, 1, 15, 0, 1, 0, 1, 1, 0, 0};
        vec[27] = '{0, 1, 0, 0, 0,  0, 0, 15, 1, 0, 1};
        vec[28] = '{0, 1, 0, 0, 0,  1, 15, 0, 1, 0, 1};
        vec[29] = '{0, 1, 0, 0, 0,  1, 0, 1, 1, 0, 2};
        vec[30] = '{0, 1, 0, 0, 0,  1, 1, 2, 1, 0, 3};
        vec[31] = '{0, 1, 0, 0, 0,  1, 2, 3, 1, 0, 4};
        vec[32] = '{0, 1, 0, 0, 0,  1, 3, 4, 1, 0, 5};
        vec[33] = '{1, 1, 1, 2, 0,  0, 3, 4, 0, 1, 6};
        vec[34] = '{0, 1, 0, 0, 0,  0, 3, 2, 1, 0, 6};
        vec[35] = '{0, 0, 0, 0, 0,  1, 2, 3, 0, 0, 6};

        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        redir_valid = 1'b0;
        redir_ip    = '0;
        step();
        step();

        // Each row: drive inputs, check the pre-edge outputs, then clock
        for (int i = 0; i < 36; i++) begin
            rst         = vec[i].rs;
            start       = vec[i].st;
            instr_ready = vec[i].rdy;
            redir_valid = vec[i].rv;
            redir_ip    = vec[i].rip;
            #1;
            chk($sformatf("row%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vec[i].v});
            chk($sformatf("row%0d instr_ip", i), {28'd0, instr_ip}, {28'd0, vec[i].iip});
            chk($sformatf("row%0d ip", i), {28'd0, ip}, {28'd0, vec[i].ipx});
            chk($sformatf("row%0d mem_en", i), {31'd0, mem_en}, {31'd0, vec[i].men});
            chk($sformatf("row%0d halted", i), {31'd0, halted}, {31'd0, vec[i].h});
            chk($sformatf("row%0d fetch_count", i), {16'd0, fetch_count}, {16'd0, vec[i].cnt});
            if (vec[i].v)
                chk($sformatf("row%0d instr", i), instr, mem[vec[i].iip]);
            else if (i == 22)
                chk("reset instr", instr, 32'd0);
            step();
        end

        // Drain to the sentinel with a bounded wait
        start       = 1'b0;
        redir_valid = 1'b0;
        instr_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!halted && n < 20) begin
                step();
                n++;
            end
            chk("halt reached within bound", {31'd0, halted}, 32'd1);
            chk("final fetch_count", {16'd0, fetch_count}, 32'd8);
            chk("sentinel not valid", {31'd0, instr_valid}, 32'd0);
            chk("mem_en low in halt", {31'd0, mem_en}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
